nn_dense_layer: RTL and testbench

Parametrised fully-connected neural-network layer: N_OUT neurons, each computing act(sum_i w[o][i]*x[i] + b[o]) over N_IN signed fixed-point inputs.
- Time-multiplexes one multiplier: one MAC per clock.
- Weights and biases live in a runtime-writable register file.
- Chains with other layers through the req/ack four-phase handshake used between network stages.
- Generalises the single-neuron, fixed-constant layer: adds width/depth parameters, full-precision accumulation, saturation and a selectable activation.

---
 rtl/nn_pkg.sv | 35 +++
 rtl/nn_activation.sv | 33 +++
 rtl/nn_dense_layer.sv | 175 +++++++++++++++++
 tb/tb_nn_dense_layer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer family: activation selectors,
// the layer FSM encoding and small arithmetic helpers used at elaboration and in datapaths.
package nn_pkg;

  localparam int ACT_IDENTITY = 0;
  localparam int ACT_HARDTANH = 1;
  localparam int ACT_RELU     = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Clamp a signed value to the range representable in 'width' signed bits.
  function automatic longint sat_narrow(input longint value, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/nn_activation.sv
// Combinational activation stage for fixed-point layers: identity, hard-tanh
// (clamp to +/-1.0 in the Q format) or ReLU, chosen at elaboration time.
module nn_activation
  import nn_pkg::*;
#(
  parameter int DW       = 8,
  parameter int FRAC     = 4,
  parameter int ACT_MODE = ACT_HARDTANH
) (
  input  logic signed [DW-1:0] z_i,
  output logic signed [DW-1:0] a_o
);

  localparam logic signed [DW-1:0] ONE     = DW'(1 <<< FRAC);
  localparam logic signed [DW-1:0] NEG_ONE = -ONE;

  always_comb begin
    // NOTE: a_o is given a value before the case so every path assigns it; a
    // combinational output left unassigned on some path would infer a latch.
    a_o = z_i;
    case (ACT_MODE)
      ACT_HARDTANH: begin
        if (z_i > ONE)          a_o = ONE;
        else if (z_i < NEG_ONE) a_o = NEG_ONE;
      end
      ACT_RELU: begin
        if (z_i < 0) a_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: N_OUT neurons over N_IN fixed-point inputs, one MAC per
// clock through a shared multiplier, runtime-writable coefficients, req/ack handshake.
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter  int DW       = 8,
  parameter  int FRAC     = 4,
  parameter  int N_IN     = 2,
  parameter  int N_OUT    = 4,
  parameter  int ACT_MODE = 1,
  localparam int ACC_W    = 2*DW + clog2(N_IN+1) + 1,
  localparam int CA_W     = clog2(N_OUT*(N_IN+1))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [N_IN*DW-1:0]  x_flat,
  output logic                ack,
  output logic                busy,
  output logic [N_OUT*DW-1:0] y_flat,
  input  logic                cfg_we,
  input  logic [CA_W-1:0]     cfg_addr,
  input  logic [DW-1:0]       cfg_wdata,
  output logic                cfg_err
);

  localparam int N_COEF = N_OUT * (N_IN + 1);
  localparam int OW     = (N_OUT > 1) ? clog2(N_OUT) : 1;
  localparam int IW     = (N_IN > 1) ? clog2(N_IN) : 1;

  state_e state_q, state_d;

  logic signed [DW-1:0]    coef_q [N_COEF];
  logic signed [DW-1:0]    x_q    [N_IN];
  logic signed [DW-1:0]    y_q    [N_OUT];
  logic signed [ACC_W-1:0] acc_q;
  logic [OW-1:0]           o_q;
  logic [IW-1:0]           i_q;
  logic [CA_W-1:0]         cidx_q;
  logic                    ack_q;
  logic                    cfg_err_q;

  logic                    busy_w;
  logic                    i_last;
  logic                    o_last;
  logic                    addr_ok;
  logic                    cfg_accept;
  logic signed [DW-1:0]    coef_cur;
  logic signed [DW-1:0]    x_cur;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_mac;
  logic signed [ACC_W-1:0] bias_term;
  logic signed [ACC_W-1:0] s_sum;
  logic signed [ACC_W-1:0] z_wide;
  logic signed [DW-1:0]    z_sat;
  logic signed [DW-1:0]    act_a;

  assign busy_w     = (state_q == S_MAC) || (state_q == S_BIAS);
  assign i_last     = (i_q == IW'(N_IN - 1));
  assign o_last     = (o_q == OW'(N_OUT - 1));
  assign addr_ok    = int'(cfg_addr) < N_COEF;
  assign cfg_accept = cfg_we && addr_ok && !busy_w;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req)    state_d = S_MAC;
      S_MAC:  if (i_last) state_d = S_BIAS;
      S_BIAS: state_d = o_last ? S_DONE : S_MAC;
      S_DONE: if (!req)   state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Coefficient register file; layout per neuron is w[0..N_IN-1] then bias.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the coefficient file is cleared by reset like ordinary state, so a
      // reset layer computes zeros until reprogrammed; this rules out RAM macros.
      for (int k = 0; k < N_COEF; k++) coef_q[k] <= '0;
    end else if (cfg_accept) begin
      coef_q[cfg_addr] <= cfg_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath. The coefficient walk is strictly sequential (weights then bias,
  // neuron by neuron), so one running index addresses the file.
  // ---------------------------------------------------------------------------
  assign coef_cur  = coef_q[cidx_q];
  assign x_cur     = x_q[i_q];
  assign prod      = (2*DW)'(coef_cur) * (2*DW)'(x_cur);
  assign acc_mac   = acc_q + ACC_W'(prod);
  assign bias_term = ACC_W'(coef_cur) <<< FRAC;
  assign s_sum     = acc_q + bias_term;
  assign z_wide    = s_sum >>> FRAC;
  assign z_sat     = DW'(sat_narrow(longint'(z_wide), DW));

  nn_activation #(
    .DW       (DW),
    .FRAC     (FRAC),
    .ACT_MODE (ACT_MODE)
  ) u_act (
    .z_i (z_sat),
    .a_o (act_a)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++)  x_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
      acc_q  <= '0;
      o_q    <= '0;
      i_q    <= '0;
      cidx_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (req) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= x_flat[k*DW +: DW];
            acc_q  <= '0;
            o_q    <= '0;
            i_q    <= '0;
            cidx_q <= '0;
          end
        end
        S_MAC: begin
          acc_q  <= acc_mac;
          i_q    <= i_q + 1'b1;
          cidx_q <= cidx_q + 1'b1;
        end
        S_BIAS: begin
          y_q[o_q] <= act_a;
          acc_q    <= '0;
          i_q      <= '0;
          cidx_q   <= cidx_q + 1'b1;
          if (!o_last) o_q <= o_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ack rises one edge after DONE is entered and drops on the edge that sees req low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      ack_q     <= (state_q == S_DONE) && req;
      cfg_err_q <= cfg_we && (busy_w || !addr_ok);
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_w;
  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_y
    assign y_flat[g*DW +: DW] = y_q[g];
  end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Self-checking bench: three layer instances (identity, hard-tanh, ReLU) driven in
// lockstep and compared against an arithmetic model of the layer equations.
module tb_nn_dense_layer;

  localparam int DW     = 8;
  localparam int FRAC   = 4;
  localparam int N_IN   = 2;
  localparam int N_OUT  = 4;
  localparam int N_COEF = N_OUT * (N_IN + 1);
  localparam int CA_W   = nn_pkg::clog2(N_COEF);
  localparam int LAT    = N_OUT * (N_IN + 1) + 1;
  localparam int LAT_MAX = 100;
  localparam int YMAX   = (1 << (DW - 1)) - 1;
  localparam int YMIN   = -(1 << (DW - 1));

  logic                clk = 1'b0;
  logic                rst;
  logic                req;
  logic [N_IN*DW-1:0]  x_flat;
  logic                cfg_we;
  logic [CA_W-1:0]     cfg_addr;
  logic [DW-1:0]       cfg_wdata;

  logic                ack_id, ack_ht, ack_re;
  logic                busy_id, busy_ht, busy_re;
  logic                err_id, err_ht, err_re;
  logic [N_OUT*DW-1:0] y_id, y_ht, y_re;

  int n_checks = 0;
  int n_errors = 0;
  int coef_m [N_COEF];
  int x_m    [N_IN];

  always #5 clk = ~clk;

  nn_dense_layer #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT), .ACT_MODE(0)) dut_id (
    .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .ack(ack_id), .busy(busy_id),
    .y_flat(y_id), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(err_id));

  nn_dense_layer #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT), .ACT_MODE(1)) dut_ht (
    .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .ack(ack_ht), .busy(busy_ht),
    .y_flat(y_ht), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(err_ht));

  nn_dense_layer #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT), .ACT_MODE(2)) dut_re (
    .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .ack(ack_re), .busy(busy_re),
    .y_flat(y_re), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(err_re));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: y[o] = act(sat(floor((sum_i w*x + b*2^FRAC) / 2^FRAC)))
  function automatic int model_y(input int mode, input int o);
    int  base;
    int  s;
    int  z;
    int  one;
    base = o * (N_IN + 1);
    one  = 1 << FRAC;
    s    = coef_m[base + N_IN] * one;
    for (int i = 0; i < N_IN; i++) s += coef_m[base + i] * x_m[i];
    z = int'($floor(real'(s) / real'(one)));
    if (z > YMAX) z = YMAX;
    if (z < YMIN) z = YMIN;
    if (mode == 1) begin
      if (z > one)  z = one;
      if (z < -one) z = -one;
    end else if (mode == 2) begin
      if (z < 0) z = 0;
    end
    return z;
  endfunction

  function automatic int y_of(input int mode, input int o);
    logic signed [DW-1:0] v;
    case (mode)
      0:       v = y_id[o*DW +: DW];
      1:       v = y_ht[o*DW +: DW];
      default: v = y_re[o*DW +: DW];
    endcase
    return int'(v);
  endfunction

  task automatic check_all_y(input string tag, input int ey [3][N_OUT]);
    for (int m = 0; m < 3; m++)
      for (int o = 0; o < N_OUT; o++)
        check($sformatf("%s_m%0d_y%0d", tag, m, o), y_of(m, o), ey[m][o]);
  endtask

  task automatic write_coef(input int addr, input int val, input bit expect_err);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = CA_W'(addr);
    cfg_wdata = DW'(val);
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err", int'(err_ht), int'(expect_err));
    if (!expect_err) coef_m[addr] = val;
  endtask

  task automatic set_x();
    for (int i = 0; i < N_IN; i++) x_flat[i*DW +: DW] = DW'(x_m[i]);
  endtask

  // One request/acknowledge cycle. Optionally: a write launched together with req,
  // or a write injected while busy (which must be rejected), and req held past ack.
  task automatic run_layer(input string tag, input int hold, input int inject_at,
                           input bit wr_with_req, input int wr_addr, input int wr_data);
    int n;
    int ey [3][N_OUT];
    for (int m = 0; m < 3; m++)
      for (int o = 0; o < N_OUT; o++) ey[m][o] = model_y(m, o);
    @(negedge clk);
    set_x();
    req = 1'b1;
    if (wr_with_req) begin
      cfg_we    = 1'b1;
      cfg_addr  = CA_W'(wr_addr);
      cfg_wdata = DW'(wr_data);
    end
    n = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (wr_with_req && n == 0) cfg_we = 1'b0;
      if (inject_at >= 0) begin
        if (n == inject_at) begin
          cfg_we    = 1'b1;
          cfg_addr  = CA_W'(wr_addr);
          cfg_wdata = DW'(wr_data);
        end else if (n == inject_at + 1) begin
          cfg_we = 1'b0;
          check({tag, "_err_busy"}, int'(err_ht), 1);
        end else if (n == inject_at + 2) begin
          check({tag, "_err_once"}, int'(err_ht), 0);
        end
      end
      if (n == 0) check({tag, "_busy_run"}, int'(busy_ht), 1);
      if (ack_ht || n >= LAT_MAX) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy_done"}, int'(busy_ht), 0);
    check({tag, "_ack_all"}, int'({ack_id, ack_re}), 3);
    check_all_y(tag, ey);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_ack_hold"}, int'(ack_ht), 1);
      for (int o = 0; o < N_OUT; o++) check({tag, "_y_hold"}, y_of(1, o), ey[1][o]);
    end
    req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_fall"}, int'(ack_ht), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ez [3][N_OUT];
    int wa;
    int wd;

    rst = 1'b1;
    req = 1'b0;
    x_flat = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    for (int k = 0; k < N_COEF; k++) coef_m[k] = 0;
    for (int m = 0; m < 3; m++)
      for (int o = 0; o < N_OUT; o++) ez[m][o] = 0;

    #12;
    check("rst_ack", int'(ack_ht), 0);
    check("rst_busy", int'(busy_ht), 0);
    check("rst_cfg_err", int'(err_ht), 0);
    check_all_y("rst", ez);
    @(negedge clk);
    rst = 1'b0;

    // Directed neuron-0 case, with req held past ack, then a re-trigger.
    write_coef(0, -23, 1'b0);
    write_coef(1, 23, 1'b0);
    write_coef(2, -9, 1'b0);
    x_m[0] = 16; x_m[1] = 16;
    run_layer("basic", 5, -1, 1'b0, 0, 0);
    run_layer("retrig", 0, -1, 1'b0, 0, 0);

    // Saturation at the DW narrowing, both signs.
    for (int a = 0; a < N_COEF; a++) write_coef(a, ((a % (N_IN + 1)) == N_IN) ? 0 : 127, 1'b0);
    x_m[0] = 127; x_m[1] = 127;
    run_layer("sat_pos", 0, -1, 1'b0, 0, 0);
    x_m[0] = -127; x_m[1] = -127;
    run_layer("sat_neg", 0, -1, 1'b0, 0, 0);

    // Floor rounding of a small negative sum.
    for (int a = 0; a < N_COEF; a++) write_coef(a, (a == 0) ? 1 : 0, 1'b0);
    x_m[0] = -1; x_m[1] = 0;
    run_layer("floor", 0, -1, 1'b0, 0, 0);

    // Write attempted while busy: rejected, results unchanged, and still unchanged after.
    x_m[0] = 37; x_m[1] = -5;
    run_layer("busy_wr", 0, 3, 1'b0, 0, 55);
    run_layer("busy_wr_after", 0, -1, 1'b0, 0, 0);

    // Out-of-range addresses in IDLE.
    write_coef(N_COEF, 11, 1'b1);
    write_coef((1 << CA_W) - 1, 11, 1'b1);

    // Randomized coefficients and inputs; the last write lands together with req.
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < N_COEF; a++) write_coef(a, int'($urandom_range(0, 255)) - 128, 1'b0);
      for (int i = 0; i < N_IN; i++) x_m[i] = int'($urandom_range(0, 255)) - 128;
      wa = int'($urandom_range(0, N_COEF - 1));
      wd = int'($urandom_range(0, 255)) - 128;
      coef_m[wa] = wd;
      run_layer($sformatf("rnd%0d", it), 0, -1, 1'b1, wa, wd);
    end

    // Reset asserted mid-computation: outputs clear asynchronously, coefficients too.
    @(negedge clk);
    x_m[0] = 50; x_m[1] = -70;
    set_x();
    req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ack", int'(ack_ht), 0);
    check("mid_rst_busy", int'(busy_ht), 0);
    check_all_y("mid_rst", ez);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N_COEF; k++) coef_m[k] = 0;
    x_m[0] = 99; x_m[1] = -99;
    run_layer("post_rst", 0, -1, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
